// File: rtl/matvec_requant_ser.sv
// rtl/matvec_requant_ser.sv - captures multiplier results, requantizes per row, streams rows out
// Optional clamp of negative results to zero: define MATVEC_REQUANT_RELU_EN.
module matvec_requant_ser #(
    parameter int R     = 8,
    parameter int W_Y   = 19,
    parameter int W_B   = 16,
    parameter int LAT   = 4,
    parameter int SHIFT = 4,
    parameter int W_OUT = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [R*W_Y-1:0]       y,
    input  logic [R*W_B-1:0]       bias,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [W_OUT-1:0]       m_data,
    output logic [$clog2(R)-1:0]   m_row,
    output logic                   m_last,
    output logic                   err
);

    localparam int RW = $clog2(R);
    localparam int AW = ((W_Y > W_B) ? W_Y : W_B) + 1;
    localparam logic signed [AW-1:0] RND  = AW'((1 << SHIFT) >> 1);
    localparam logic signed [AW-1:0] MAXV = AW'((1 << (W_OUT - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = AW'(-(1 << (W_OUT - 1)));
    localparam logic [RW-1:0]        LAST_ROW = RW'(R - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic logic [W_OUT-1:0] requant(input logic signed [W_Y-1:0] yv,
                                                 input logic signed [W_B-1:0] bv);
        logic signed [AW-1:0] a;
        logic signed [AW-1:0] s;
        a = AW'(yv) + AW'(bv) + RND;
        s = a >>> SHIFT;
`ifdef MATVEC_REQUANT_RELU_EN
        if (s < 0) s = '0;
`endif
        if (s > MAXV)      s = MAXV;
        else if (s < MINV) s = MINV;
        return s[W_OUT-1:0];
    endfunction

    state_t             state;
    state_t             state_n;
    logic [LAT-1:0]     vld_sr;
    logic [1:0]         inflight;
    logic [1:0]         occ;
    logic               wr_ptr;
    logic               rd_ptr;
    logic               rd_d;
    logic               acc;
    logic               fire;
    logic               hs;
    logic               pop;
    logic               valid_d;
    logic [RW-1:0]      row_d;
    logic [W_OUT-1:0]   data_d;
    logic [W_OUT-1:0]   req    [R];
    logic [W_OUT-1:0]   slot_q [2][R];

    // A credit covers a vector from acceptance until its last row is popped.
    assign in_ready = ({1'b0, inflight} + {1'b0, occ}) < 3'd2;
    assign acc      = in_valid & in_ready;
    assign fire     = vld_sr[LAT-1];
    assign hs       = m_valid & m_ready;
    assign pop      = hs & (m_row == LAST_ROW);

    always_comb begin
        for (int r = 0; r < R; r++) begin
            req[r] = requant(y[r*W_Y +: W_Y], bias[r*W_B +: W_B]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (occ != 2'd0) state_n = STREAM;
            STREAM:  if (pop && occ != 2'd2) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        valid_d = m_valid;
        row_d   = m_row;
        data_d  = m_data;
        rd_d    = rd_ptr;
        case (state)
            IDLE: begin
                if (occ != 2'd0) begin
                    valid_d = 1'b1;
                    row_d   = '0;
                    data_d  = slot_q[rd_ptr][0];
                end
            end
            STREAM: begin
                if (pop) begin
                    rd_d  = ~rd_ptr;
                    row_d = '0;
                    // Other slot already full: chain its row 0 without a bubble.
                    if (occ == 2'd2) begin
                        valid_d = 1'b1;
                        data_d  = slot_q[~rd_ptr][0];
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (hs) begin
                    row_d  = m_row + 1'b1;
                    data_d = slot_q[rd_ptr][row_d];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_sr   <= '0;
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            err      <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_row    <= '0;
            m_last   <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                for (int r = 0; r < R; r++) begin
                    slot_q[s][r] <= '0;
                end
            end
        end else begin
            vld_sr   <= LAT'({vld_sr, acc});
            inflight <= inflight + {1'b0, acc} - {1'b0, fire};
            occ      <= occ + {1'b0, fire} - {1'b0, pop};
            if (in_valid && !in_ready) err <= 1'b1;
            if (fire) begin
                for (int r = 0; r < R; r++) begin
                    slot_q[wr_ptr][r] <= req[r];
                end
                wr_ptr <= ~wr_ptr;
            end
            rd_ptr  <= rd_d;
            m_valid <= valid_d;
            m_data  <= data_d;
            m_row   <= row_d;
            m_last  <= valid_d & (row_d == LAST_ROW);
        end
    end

endmodule
